cover_hit_collector: RTL and testbench

- Consumer end of the toggle-coverage reporting path: accepts per-cycle groups of cover-point valid bits, each tagged with its base cover index.
- Deduplicates hits against a seen-bitmap and streams each first-time cover index out on a valid/ready channel to the host/DPI drain logic.
- Keeps a running count of unique hits.
- Hardware counterpart to the per-point DPI reporting used in simulation, for emulation and formal runs.

---
 rtl/cover_hit_collector_if.sv | 32 +++
 rtl/cover_hit_collector.sv | 150 +++++++++++++++
 tb/tb_cover_hit_collector.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/cover_hit_collector_if.sv
// Handshake bundle between the coverage hit source, the collector and the drain side.
//   in_valid/in_base/in_bits/in_ready   : cover-group intake channel
//   out_valid/out_index/out_ready       : unique-hit output channel
//   clear_req/clear_busy                : coverage wipe request and walk status
//   hit_count/oor_err                   : unique-hit counter and sticky range error
// master = producer/consumer side (testbench, host), slave = collector.
interface cover_hit_collector_if #(
    parameter int unsigned IN_WIDTH = 8,
    parameter int unsigned INDEX_W  = 16
);
    logic                in_valid;
    logic [INDEX_W-1:0]  in_base;
    logic [IN_WIDTH-1:0] in_bits;
    logic                in_ready;
    logic                out_valid;
    logic [INDEX_W-1:0]  out_index;
    logic                out_ready;
    logic                clear_req;
    logic                clear_busy;
    logic [INDEX_W-1:0]  hit_count;
    logic                oor_err;

    modport master (
        output in_valid, in_base, in_bits, out_ready, clear_req,
        input  in_ready, out_valid, out_index, clear_busy, hit_count, oor_err
    );

    modport slave (
        input  in_valid, in_base, in_bits, out_ready, clear_req,
        output in_ready, out_valid, out_index, clear_busy, hit_count, oor_err
    );
endinterface

// File: rtl/cover_hit_collector.sv
// Coverage hit collector: accepts groups of cover bits tagged with a base index,
// filters repeats against a seen-bitmap and streams first-time indices through a
// registered FIFO. Keeps a unique-hit count and a sticky out-of-range flag.
// Ports:
//   clock  : sole clock, rising edge
//   reset  : asynchronous, active-low
//   bus    : cover_hit_collector_if.slave (intake, output, clear and status signals)
module cover_hit_collector #(
    parameter int unsigned IN_WIDTH    = 8,
    parameter int unsigned INDEX_W     = 16,
    parameter int unsigned COVER_TOTAL = 38253,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    cover_hit_collector_if.slave  bus
);
    localparam int unsigned K_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam int unsigned A_W = $clog2(FIFO_DEPTH);
    localparam int unsigned C_W = A_W + 1;
    localparam int unsigned X_W = INDEX_W + 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t              state;
    logic [INDEX_W-1:0]  ptr;
    logic [INDEX_W-1:0]  base;
    logic [IN_WIDTH-1:0] pending;
    logic [INDEX_W-1:0]  hit_count;
    logic                oor_err;

    // Seen-bitmap has no reset; the CLEAR walk wipes it.
    logic [COVER_TOTAL-1:0] seen;

    logic [INDEX_W-1:0] mem [FIFO_DEPTH];
    logic [A_W-1:0]     rd_ptr;
    logic [A_W-1:0]     wr_ptr;
    logic [C_W-1:0]     count;

    logic [K_W-1:0]     sel_k;
    logic [X_W-1:0]     idx;
    logic               idx_in;
    logic [INDEX_W-1:0] idx_cl;
    logic               seen_hit;
    logic               active;
    logic               processing;
    logic               fifo_full;
    logic               fifo_empty;
    logic               do_push;
    logic               do_pop;
    logic               do_accept;
    logic               bit_done;

    // Lowest set bit of pending.
    always_comb begin
        sel_k = '0;
        for (int i = IN_WIDTH - 1; i >= 0; i--) begin
            if (pending[i]) sel_k = K_W'(i);
        end
    end

    // Index computed one bit wider so base+k never wraps.
    assign idx      = {1'b0, base} + X_W'(sel_k);
    assign idx_in   = idx < X_W'(COVER_TOTAL);
    assign idx_cl   = idx_in ? idx[INDEX_W-1:0] : '0;
    assign seen_hit = seen[idx_cl];

    assign active     = (state == ST_RUN) && !bus.clear_req;
    assign processing = active && (pending != '0);
    assign fifo_full  = (count == C_W'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign do_pop     = !fifo_empty && bus.out_ready;
    assign do_push    = processing && idx_in && !seen_hit && !fifo_full;
    // A bit retires unless it is a new in-range index blocked by a full FIFO.
    assign bit_done   = processing && (!idx_in || seen_hit || !fifo_full);
    assign do_accept  = active && (pending == '0) && bus.in_valid;

    assign bus.in_ready   = active && (pending == '0);
    assign bus.out_valid  = !fifo_empty;
    assign bus.out_index  = mem[rd_ptr];
    assign bus.clear_busy = (state == ST_CLEAR);
    assign bus.hit_count  = hit_count;
    assign bus.oor_err    = oor_err;

    // Control FSM, group processing and FIFO bookkeeping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_CLEAR;
            ptr       <= '0;
            base      <= '0;
            pending   <= '0;
            hit_count <= '0;
            oor_err   <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    ptr <= ptr + INDEX_W'(1);
                    if (ptr == INDEX_W'(COVER_TOTAL - 1)) begin
                        state <= ST_RUN;
                        ptr   <= '0;
                    end
                end
                default: begin
                    if (bus.clear_req) begin
                        // Wipe everything; any pop on this edge is dropped with the flush.
                        state     <= ST_CLEAR;
                        ptr       <= '0;
                        pending   <= '0;
                        hit_count <= '0;
                        oor_err   <= 1'b0;
                        rd_ptr    <= '0;
                        wr_ptr    <= '0;
                        count     <= '0;
                    end else begin
                        if (do_accept) begin
                            pending <= bus.in_bits;
                            base    <= bus.in_base;
                        end
                        if (bit_done) pending[sel_k] <= 1'b0;
                        if (processing && !idx_in) oor_err <= 1'b1;
                        if (do_push) begin
                            mem[wr_ptr] <= idx[INDEX_W-1:0];
                            wr_ptr      <= wr_ptr + A_W'(1);
                            if (hit_count != INDEX_W'(COVER_TOTAL))
                                hit_count <= hit_count + INDEX_W'(1);
                        end
                        if (do_pop) rd_ptr <= rd_ptr + A_W'(1);
                        count <= count + C_W'(do_push) - C_W'(do_pop);
                    end
                end
            endcase
        end
    end

    // Seen-bitmap: wiped one entry per cycle during CLEAR, set on push.
    always_ff @(posedge clock) begin
        if (state == ST_CLEAR) begin
            seen[ptr] <= 1'b0;
        end else if (do_push) begin
            seen[idx_cl] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cover_hit_collector.sv
module tb_cover_hit_collector;
    localparam int unsigned IN_WIDTH    = 8;
    localparam int unsigned INDEX_W     = 16;
    localparam int unsigned COVER_TOTAL = 38253;
    localparam int unsigned FIFO_DEPTH  = 16;

    logic clock;
    logic reset;
    int   checks;
    int   errors;
    logic [INDEX_W-1:0] exp_q[$];

    cover_hit_collector_if #(.IN_WIDTH(IN_WIDTH), .INDEX_W(INDEX_W)) bus ();

    cover_hit_collector #(
        .IN_WIDTH(IN_WIDTH), .INDEX_W(INDEX_W),
        .COVER_TOTAL(COVER_TOTAL), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!bus.in_ready && n < 300) begin
            tick();
            n++;
        end
        check(tag, 32'(bus.in_ready), 32'd1);
    endtask

    // Accept one group (waits for in_ready), optionally registering expected outputs.
    task automatic send(input logic [INDEX_W-1:0] b, input logic [IN_WIDTH-1:0] bits,
                        input int first_new, input int count_new);
        wait_ready("send_ready");
        for (int i = 0; i < count_new; i++) exp_q.push_back(INDEX_W'(first_new + i));
        bus.in_valid = 1'b1;
        bus.in_base  = b;
        bus.in_bits  = bits;
        tick();
        bus.in_valid = 1'b0;
        bus.in_bits  = '0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || !bus.in_ready || bus.out_valid) && n < 500) begin
            tick();
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic count_clear(input string tag);
        int n = 0;
        while (bus.clear_busy && n < 40000) begin
            tick();
            n++;
        end
        check(tag, 32'(n), 32'(COVER_TOTAL));
    endtask

    // Scoreboard: every accepted pop must match the head of the expected queue.
    always @(negedge clock) begin
        if (reset && bus.out_valid && bus.out_ready && !bus.clear_req) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL scoreboard_unexpected: observed index %0d expected none", bus.out_index);
            end
            if (exp_q.size() != 0) begin
                logic [INDEX_W-1:0] e;
                e = exp_q.pop_front();
                checks++;
                assert (bus.out_index === e) else begin
                    errors++;
                    $error("FAIL scoreboard_index: observed %0d expected %0d", bus.out_index, e);
                end
            end
        end
    end

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_base   = '0;
        bus.in_bits   = '0;
        bus.out_ready = 1'b1;
        bus.clear_req = 1'b0;

        // Reset values
        tick(); tick(); tick();
        check("rst_in_ready",   32'(bus.in_ready),   32'd0);
        check("rst_out_valid",  32'(bus.out_valid),  32'd0);
        check("rst_out_index",  32'(bus.out_index),  32'd0);
        check("rst_clear_busy", 32'(bus.clear_busy), 32'd1);
        check("rst_hit_count",  32'(bus.hit_count),  32'd0);
        check("rst_oor_err",    32'(bus.oor_err),    32'd0);

        // Reset applied mid-walk restarts the walk
        reset = 1'b1;
        repeat (50) tick();
        check("walk_busy_mid", 32'(bus.clear_busy), 32'd1);
        reset = 1'b0;
        #1;
        check("midrst_busy",     32'(bus.clear_busy), 32'd1);
        check("midrst_in_ready", 32'(bus.in_ready),   32'd0);
        tick();
        reset = 1'b1;

        // Full clear walk after release
        count_clear("init_clear_len");
        check("run_in_ready",  32'(bus.in_ready),  32'd1);
        check("run_out_valid", 32'(bus.out_valid), 32'd0);
        check("run_hit_count", 32'(bus.hit_count), 32'd0);

        // Group 100 / 1000_0101: outputs 100,102,107 on consecutive cycles
        exp_q.push_back(16'd100);
        exp_q.push_back(16'd102);
        exp_q.push_back(16'd107);
        bus.in_valid = 1'b1;
        bus.in_base  = 16'd100;
        bus.in_bits  = 8'b1000_0101;
        tick();
        bus.in_valid = 1'b0;
        bus.in_bits  = '0;
        check("g1_in_ready_t0",  32'(bus.in_ready),  32'd0);
        check("g1_out_valid_t0", 32'(bus.out_valid), 32'd0);
        tick();
        check("g1_out_valid_t1", 32'(bus.out_valid), 32'd1);
        check("g1_out_index_t1", 32'(bus.out_index), 32'd100);
        tick();
        check("g1_out_index_t2", 32'(bus.out_index), 32'd102);
        check("g1_in_ready_t2",  32'(bus.in_ready),  32'd0);
        tick();
        check("g1_out_index_t3", 32'(bus.out_index), 32'd107);
        check("g1_in_ready_t3",  32'(bus.in_ready),  32'd1);
        tick();
        check("g1_out_valid_t4", 32'(bus.out_valid), 32'd0);
        check("g1_hit_count",    32'(bus.hit_count), 32'd3);
        check("g1_queue_empty",  32'(exp_q.size()),  32'd0);

        // Same group again: all duplicates, in_ready back after 3 cycles
        bus.in_valid = 1'b1;
        bus.in_base  = 16'd100;
        bus.in_bits  = 8'b1000_0101;
        tick();
        bus.in_valid = 1'b0;
        bus.in_bits  = '0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("dup_out_valid", 32'(bus.out_valid), 32'd0);
            check("dup_in_ready",  32'(bus.in_ready),  32'(i == 3));
        end
        check("dup_hit_count", 32'(bus.hit_count), 32'd3);

        // Backpressure: 24 new indices into a 16-entry FIFO, then drain
        bus.out_ready = 1'b0;
        send(16'd0,  8'hFF, 0,  8);
        send(16'd8,  8'hFF, 8,  8);
        send(16'd16, 8'hFF, 16, 8);
        repeat (5) tick();
        check("bp_out_valid", 32'(bus.out_valid), 32'd1);
        check("bp_stalled",   32'(bus.in_ready),  32'd0);
        check("bp_hit_count", 32'(bus.hit_count), 32'd19);
        bus.out_ready = 1'b1;
        wait_drain("bp_drain");
        check("bp_hit_final", 32'(bus.hit_count), 32'd27);
        check("bp_oor_clear", 32'(bus.oor_err),   32'd0);

        // Upper boundary: 38248..38252 valid, 38253..38255 out of range
        send(16'd38248, 8'hFF, 38248, 5);
        wait_drain("oor_drain");
        check("oor_err_set",   32'(bus.oor_err),   32'd1);
        check("oor_hit_count", 32'(bus.hit_count), 32'd32);

        // Clear with a pending group offered and a non-empty FIFO
        bus.out_ready = 1'b0;
        send(16'd200, 8'h01, 200, 1);
        tick(); tick();
        check("clr_pre_out_valid", 32'(bus.out_valid), 32'd1);
        bus.clear_req = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_base   = 16'd300;
        bus.in_bits   = 8'hFF;
        #1;
        check("clr_in_ready_low", 32'(bus.in_ready), 32'd0);
        tick();
        bus.clear_req = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_bits   = '0;
        exp_q.delete();
        check("clr_out_valid",  32'(bus.out_valid),  32'd0);
        check("clr_hit_count",  32'(bus.hit_count),  32'd0);
        check("clr_oor_err",    32'(bus.oor_err),    32'd0);
        check("clr_busy",       32'(bus.clear_busy), 32'd1);
        count_clear("clr_walk_len");
        check("clr_post_out_valid", 32'(bus.out_valid), 32'd0);
        check("clr_post_hit_count", 32'(bus.hit_count), 32'd0);

        // Previously seen index reports again after the wipe
        bus.out_ready = 1'b1;
        send(16'd100, 8'h01, 100, 1);
        wait_drain("reseen_drain");
        check("reseen_hit_count", 32'(bus.hit_count), 32'd1);
        check("final_queue",      32'(exp_q.size()),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
